// File: rtl/cam_reg_arbiter_if.sv
// rtl/cam_reg_arbiter_if.sv - requester and I2C-controller signal bundle for cam_reg_arbiter
interface cam_reg_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req0_done;
  logic       req0_err;
  logic       req1_valid;
  logic [7:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       req1_done;
  logic       req1_err;
  logic       ctl_init_done;
  logic       ctl_device_rdy;
  logic       ctl_error;
  logic [7:0] ctl_data;
  logic       ctl_store;
  logic       ctl_send;
  logic       busy;
  logic       timeout;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output ctl_init_done, ctl_device_rdy, ctl_error,
    input  req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
    input  ctl_data, ctl_store, ctl_send, busy, timeout
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  ctl_init_done, ctl_device_rdy, ctl_error,
    output req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
    output ctl_data, ctl_store, ctl_send, busy, timeout
  );
endinterface

// File: rtl/cam_reg_arbiter.sv
// rtl/cam_reg_arbiter.sv - two-port round-robin arbiter feeding camera register writes
// into a byte-buffered I2C controller, with completion, error and timeout reporting.
module cam_reg_arbiter #(
  parameter int               CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  cam_reg_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD_ADDR, LOAD_DATA, LOAD_END, SEND, SEND_END, WAIT_DONE, RESP
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = TIMEOUT_CYCLES - CNT_W'(1);

  state_t           state;
  logic             gnt;
  logic             last_gnt;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] cnt;
  logic             seen_low;

  logic can_grant;
  logic pick;
  logic wd_accept;
  logic wd_exit;
  logic wd_err;
  logic wd_to;

  assign can_grant = bus.ctl_init_done && bus.ctl_device_rdy &&
                     (bus.req0_valid || bus.req1_valid);
  // On a tie the port that did not win last time goes next.
  assign pick      = (bus.req0_valid && bus.req1_valid) ? ~last_gnt : bus.req1_valid;

  // The controller reports idle before it has started, so ready only
  // counts as completion once it has been seen low in this wait.
  assign wd_accept = seen_low && bus.ctl_device_rdy;
  assign wd_exit   = bus.ctl_error || wd_accept || (cnt == LIMIT);
  assign wd_err    = bus.ctl_error || !wd_accept;
  assign wd_to     = !bus.ctl_error && !wd_accept && (cnt == LIMIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      gnt            <= 1'b0;
      last_gnt       <= 1'b1;
      data_q         <= 8'h00;
      cnt            <= '0;
      seen_low       <= 1'b0;
      bus.req0_ready <= 1'b0;
      bus.req1_ready <= 1'b0;
      bus.req0_done  <= 1'b0;
      bus.req1_done  <= 1'b0;
      bus.req0_err   <= 1'b0;
      bus.req1_err   <= 1'b0;
      bus.ctl_data   <= 8'h00;
      bus.ctl_store  <= 1'b0;
      bus.ctl_send   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.timeout    <= 1'b0;
    end else begin
      bus.req0_ready <= 1'b0;
      bus.req1_ready <= 1'b0;
      bus.req0_done  <= 1'b0;
      bus.req1_done  <= 1'b0;
      bus.req0_err   <= 1'b0;
      bus.req1_err   <= 1'b0;
      bus.ctl_send   <= 1'b0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            gnt            <= pick;
            last_gnt       <= pick;
            data_q         <= pick ? bus.req1_data : bus.req0_data;
            bus.ctl_data   <= pick ? bus.req1_addr : bus.req0_addr;
            bus.ctl_store  <= 1'b1;
            bus.req0_ready <= ~pick;
            bus.req1_ready <= pick;
            bus.busy       <= 1'b1;
            state          <= LOAD_ADDR;
          end
        end
        LOAD_ADDR: begin
          bus.ctl_data <= data_q;
          state        <= LOAD_DATA;
        end
        LOAD_DATA: begin
          bus.ctl_store <= 1'b0;
          state         <= LOAD_END;
        end
        LOAD_END: begin
          bus.ctl_send <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          state <= SEND_END;
        end
        SEND_END: begin
          cnt      <= '0;
          seen_low <= 1'b0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + CNT_W'(1);
          if (!bus.ctl_device_rdy) seen_low <= 1'b1;
          if (wd_exit) begin
            bus.req0_done <= ~gnt;
            bus.req1_done <= gnt;
            bus.req0_err  <= ~gnt & wd_err;
            bus.req1_err  <= gnt & wd_err;
            if (wd_to) bus.timeout <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_reg_arbiter.sv
// tb/tb_cam_reg_arbiter.sv - directed vector bench for cam_reg_arbiter
module tb_cam_reg_arbiter;

  logic clk;
  logic rst_n;

  cam_reg_arbiter_if bif ();
  cam_reg_arbiter_if tif ();

  cam_reg_arbiter dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bif));
  cam_reg_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut_t (.sys_clk(clk), .sys_rst_n(rst_n), .bus(tif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // field order: n, v0,a0,d0, v1,a1,d1, init,rdy,cerr,
  //              r0,r1,dn0,dn1,e0,e1,st,sd,data,busy,to
  typedef struct {
    int         n;
    logic       v0;
    logic [7:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] a1;
    logic [7:0] d1;
    logic       init;
    logic       rdy;
    logic       cerr;
    logic       r0;
    logic       r1;
    logic       dn0;
    logic       dn1;
    logic       e0;
    logic       e1;
    logic       st;
    logic       sd;
    logic [7:0] data;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[18];
  int   nvec;
  int   nerr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] obs();
    return {bif.req0_ready, bif.req1_ready, bif.req0_done, bif.req1_done,
            bif.req0_err, bif.req1_err, bif.ctl_store, bif.ctl_send,
            bif.ctl_data, bif.busy, bif.timeout};
  endfunction

  initial begin
    int grants[8];
    int ng;
    int ndone;
    int rdy_t;
    int done_t;
    int sends;
    int rt;
    logic [17:0] e;

    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bif.req0_valid = 0; bif.req0_addr = 0; bif.req0_data = 0;
    bif.req1_valid = 0; bif.req1_addr = 0; bif.req1_data = 0;
    bif.ctl_init_done = 0; bif.ctl_device_rdy = 1; bif.ctl_error = 0;
    tif.req0_valid = 0; tif.req0_addr = 0; tif.req0_data = 0;
    tif.req1_valid = 0; tif.req1_addr = 0; tif.req1_data = 0;
    tif.ctl_init_done = 0; tif.ctl_device_rdy = 1; tif.ctl_error = 0;

    vecs[0]  = '{5,  1,8'h12,8'h80, 0,8'h00,8'h00, 0,1,0, 0,0,0,0,0,0,0,0,8'h00,0,0};
    vecs[1]  = '{1,  1,8'h12,8'h80, 0,8'h00,8'h00, 1,1,0, 1,0,0,0,0,0,1,0,8'h12,1,0};
    vecs[2]  = '{1,  0,8'hFF,8'hFF, 0,8'h00,8'h00, 1,1,0, 0,0,0,0,0,0,1,0,8'h80,1,0};
    vecs[3]  = '{1,  0,8'hFF,8'hFF, 0,8'h00,8'h00, 1,1,0, 0,0,0,0,0,0,0,0,8'h80,1,0};
    vecs[4]  = '{1,  0,8'hFF,8'hFF, 0,8'h00,8'h00, 1,1,0, 0,0,0,0,0,0,0,1,8'h80,1,0};
    vecs[5]  = '{1,  0,8'hFF,8'hFF, 0,8'h00,8'h00, 1,1,0, 0,0,0,0,0,0,0,0,8'h80,1,0};
    vecs[6]  = '{20, 0,8'hFF,8'hFF, 0,8'h00,8'h00, 1,0,0, 0,0,0,0,0,0,0,0,8'h80,1,0};
    vecs[7]  = '{1,  0,8'hFF,8'hFF, 0,8'h00,8'h00, 1,1,0, 0,0,1,0,0,0,0,0,8'h80,1,0};
    vecs[8]  = '{1,  0,8'hFF,8'hFF, 0,8'h00,8'h00, 1,1,0, 0,0,0,0,0,0,0,0,8'h80,0,0};
    vecs[9]  = '{1,  0,8'h00,8'h00, 1,8'h34,8'h56, 1,1,0, 0,1,0,0,0,0,1,0,8'h34,1,0};
    vecs[10] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,1,0, 0,0,0,0,0,0,1,0,8'h56,1,0};
    vecs[11] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,1,0, 0,0,0,0,0,0,0,0,8'h56,1,0};
    vecs[12] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,1,0, 0,0,0,0,0,0,0,1,8'h56,1,0};
    vecs[13] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,1,0, 0,0,0,0,0,0,0,0,8'h56,1,0};
    vecs[14] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,1,0, 0,0,0,0,0,0,0,0,8'h56,1,0};
    vecs[15] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,0,0, 0,0,0,0,0,0,0,0,8'h56,1,0};
    vecs[16] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,1,1, 0,0,0,1,0,1,0,0,8'h56,1,0};
    vecs[17] = '{1,  0,8'h00,8'h00, 0,8'hFF,8'hFF, 1,1,0, 0,0,0,0,0,0,0,0,8'h56,0,0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_outputs", 32'(obs()), 32'h0);
    chk("reset_timeout_t", 32'(tif.timeout), 32'h0);

    // gating, single write, error-with-ready
    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        bif.req0_valid = vecs[i].v0; bif.req0_addr = vecs[i].a0; bif.req0_data = vecs[i].d0;
        bif.req1_valid = vecs[i].v1; bif.req1_addr = vecs[i].a1; bif.req1_data = vecs[i].d1;
        bif.ctl_init_done = vecs[i].init;
        bif.ctl_device_rdy = vecs[i].rdy;
        bif.ctl_error = vecs[i].cerr;
        step();
        e = {vecs[i].r0, vecs[i].r1, vecs[i].dn0, vecs[i].dn1, vecs[i].e0, vecs[i].e1,
             vecs[i].st, vecs[i].sd, vecs[i].data, vecs[i].busy, vecs[i].to};
        chk($sformatf("vec%0d_cyc%0d", i, k), 32'(obs()), 32'(e));
      end
    end

    // contention: controller drops ready 1 cycle after send for 3 cycles
    bif.req0_valid = 1; bif.req0_addr = 8'hA0; bif.req0_data = 8'hA1;
    bif.req1_valid = 1; bif.req1_addr = 8'hB0; bif.req1_data = 8'hB1;
    bif.ctl_device_rdy = 1; bif.ctl_error = 0;
    ng = 0; ndone = 0; rdy_t = 0; done_t = 0; sends = -100;
    for (int cyc = 0; cyc < 300 && ndone < 4; cyc++) begin
      step();
      if (bif.req0_ready || bif.req1_ready) begin
        if (ng < 8) grants[ng] = int'(bif.req1_ready);
        if (ng > 0) chk("grant_gap", 32'(cyc - done_t), 32'd2);
        if (ng < 4) chk($sformatf("grant%0d_port", ng), 32'(bif.req1_ready), 32'(ng % 2));
        rdy_t = cyc;
        ng++;
      end
      if (bif.req0_done || bif.req1_done) begin
        chk($sformatf("done%0d_port", ndone), 32'(bif.req1_done), 32'(grants[ndone % 8]));
        chk($sformatf("done%0d_latency", ndone), 32'(cyc - rdy_t), 32'd7);
        chk($sformatf("done%0d_err", ndone), 32'(bif.req0_err | bif.req1_err), 32'd0);
        done_t = cyc;
        ndone++;
      end
      if (bif.ctl_send) sends = cyc;
      bif.ctl_device_rdy = !(cyc >= sends && cyc < sends + 3);
    end
    bif.req0_valid = 0; bif.req1_valid = 0;
    bif.ctl_device_rdy = 1;
    chk("contention_done_count", 32'(ndone), 32'd4);
    step(); step();
    chk("contention_idle", 32'(bif.busy), 32'd0);

    // reset in LOAD_DATA
    bif.req0_valid = 1; bif.req0_addr = 8'hAB; bif.req0_data = 8'hCD;
    step();
    chk("rst_grant", 32'(bif.req0_ready), 32'd1);
    bif.req0_valid = 0;
    step();
    chk("rst_load_data", 32'({bif.ctl_store, bif.ctl_data}), 32'h1CD);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(obs()), 32'h0);
    step(); step();
    rst_n = 1'b1;
    rt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bif.req0_done || bif.req0_err || bif.busy || bif.ctl_store || bif.ctl_send) rt++;
    end
    chk("rst_no_done_after", 32'(rt), 32'd0);
    bif.req0_valid = 1; bif.req0_addr = 8'h5A; bif.req0_data = 8'h5B;
    step();
    chk("rst_regrant", 32'({bif.req0_ready, bif.req1_ready, bif.ctl_data}), 32'h25A);
    bif.req0_valid = 0;

    // timeout with ready held high on the 16-cycle instance
    tif.ctl_init_done = 1; tif.ctl_device_rdy = 1;
    tif.req0_valid = 1; tif.req0_addr = 8'h01; tif.req0_data = 8'h02;
    step();
    chk("to_grant", 32'(tif.req0_ready), 32'd1);
    tif.req0_valid = 0;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 20) chk("to_not_yet", 32'({tif.req0_done, tif.timeout}), 32'd0);
      if (k == 21) chk("to_done_err", 32'({tif.req0_done, tif.req0_err, tif.req1_done, tif.timeout}), 32'hD);
    end
    step(); step(); step();
    chk("to_sticky", 32'({tif.timeout, tif.busy, tif.req0_done}), 32'h4);
    chk("to_main_clear", 32'(bif.timeout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
